fp_compare: RTL and testbench

- Parametrised multi-cycle IEEE-754 comparator; successor to the single-predicate equality checker.
- Evaluates one of four predicates (EQ, LT, LE, UNORD) on two operands, with full NaN/zero classification and IEEE invalid-operation signalling.
- Sits beside the other FPU arithmetic units; uses a start/done handshake so the FPU sequencer can issue back-to-back compares.

---
 rtl/fp_compare_if.sv | 24 ++
 rtl/fp_compare.sv | 137 +++++++++++++
 tb/tb_fp_compare.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_compare_if.sv
// Start/done handshake and operand/result bundle between the FPU sequencer and fp_compare.
interface fp_compare_if #(
  parameter int unsigned PRECISION = 32
);
  logic                 start;
  logic [1:0]           op;
  logic [PRECISION-1:0] fp_a;
  logic [PRECISION-1:0] fp_b;
  logic                 busy;
  logic                 done;
  logic                 res;
  logic                 invalid;
  logic                 unordered;

  modport master (
    output start, op, fp_a, fp_b,
    input  busy, done, res, invalid, unordered
  );

  modport slave (
    input  start, op, fp_a, fp_b,
    output busy, done, res, invalid, unordered
  );
endinterface

// File: rtl/fp_compare.sv
// Multi-cycle IEEE-754 comparator (EQ/LT/LE/UNORD) with NaN classification and invalid flag.
// Define FP_COMPARE_FTZ_EN to flush subnormal operands to signed zero during classification.
module fp_compare #(
  parameter int unsigned PRECISION     = 32,
  parameter int unsigned EXP_SIZE      = 8,
  parameter int unsigned MANTISSA_SIZE = 23
) (
  input  logic         clk,
  input  logic         reset,
  fp_compare_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CLASSIFY, COMPARE, DONE} state_t;
  typedef enum logic [1:0] {OP_EQ, OP_LT, OP_LE, OP_UNORD} op_t;

  state_t               state_q;
  op_t                  op_q;
  logic [PRECISION-1:0] a_q, b_q;
  logic                 a_zero_q, a_nan_q, a_snan_q;
  logic                 b_zero_q, b_nan_q, b_snan_q;
  logic                 busy_q, done_q, res_q, invalid_q, unordered_q;

  logic [EXP_SIZE-1:0]      a_exp, b_exp;
  logic [MANTISSA_SIZE-1:0] a_frac, b_frac;
  logic                     a_zero_d, a_nan_d, a_snan_d;
  logic                     b_zero_d, b_nan_d, b_snan_d;
  logic                     both_zero, any_nan, any_snan, eq_w, lt_w;
  logic                     res_d, invalid_d;

  assign a_exp  = a_q[PRECISION-2 -: EXP_SIZE];
  assign b_exp  = b_q[PRECISION-2 -: EXP_SIZE];
  assign a_frac = a_q[MANTISSA_SIZE-1:0];
  assign b_frac = b_q[MANTISSA_SIZE-1:0];

  always_comb begin
    a_nan_d  = (&a_exp) && (|a_frac);
    b_nan_d  = (&b_exp) && (|b_frac);
    a_snan_d = a_nan_d && !a_frac[MANTISSA_SIZE-1];
    b_snan_d = b_nan_d && !b_frac[MANTISSA_SIZE-1];
`ifdef FP_COMPARE_FTZ_EN
    a_zero_d = ~|a_exp;
    b_zero_d = ~|b_exp;
`else
    a_zero_d = (~|a_exp) && (~|a_frac);
    b_zero_d = (~|b_exp) && (~|b_frac);
`endif
  end

  // Sign-magnitude ordering: equal signs compare magnitudes, reversed when negative.
  always_comb begin
    both_zero = a_zero_q & b_zero_q;
    any_nan   = a_nan_q | b_nan_q;
    any_snan  = a_snan_q | b_snan_q;
    eq_w      = both_zero || (a_q == b_q);
    if (both_zero)
      lt_w = 1'b0;
    else if (a_q[PRECISION-1] != b_q[PRECISION-1])
      lt_w = a_q[PRECISION-1];
    else if (a_q[PRECISION-1])
      lt_w = a_q[PRECISION-2:0] > b_q[PRECISION-2:0];
    else
      lt_w = a_q[PRECISION-2:0] < b_q[PRECISION-2:0];

    res_d     = 1'b0;
    invalid_d = any_snan;
    case (op_q)
      OP_EQ:    res_d = eq_w & ~any_nan;
      OP_LT:    begin res_d = lt_w & ~any_nan;           invalid_d = any_nan; end
      OP_LE:    begin res_d = (lt_w | eq_w) & ~any_nan;  invalid_d = any_nan; end
      OP_UNORD: res_d = any_nan;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= OP_EQ;
      a_q         <= '0;
      b_q         <= '0;
      a_zero_q    <= 1'b0;
      a_nan_q     <= 1'b0;
      a_snan_q    <= 1'b0;
      b_zero_q    <= 1'b0;
      b_nan_q     <= 1'b0;
      b_snan_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_q       <= 1'b0;
      invalid_q   <= 1'b0;
      unordered_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.fp_a;
            b_q     <= bus.fp_b;
            op_q    <= op_t'(bus.op);
            busy_q  <= 1'b1;
            state_q <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          a_zero_q <= a_zero_d;
          a_nan_q  <= a_nan_d;
          a_snan_q <= a_snan_d;
          b_zero_q <= b_zero_d;
          b_nan_q  <= b_nan_d;
          b_snan_q <= b_snan_d;
`ifdef FP_COMPARE_FTZ_EN
          if (a_zero_d) a_q <= {a_q[PRECISION-1], {(PRECISION-1){1'b0}}};
          if (b_zero_d) b_q <= {b_q[PRECISION-1], {(PRECISION-1){1'b0}}};
`endif
          state_q <= COMPARE;
        end
        COMPARE: begin
          res_q       <= res_d;
          invalid_q   <= invalid_d;
          unordered_q <= any_nan;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.res       = res_q;
  assign bus.invalid   = invalid_q;
  assign bus.unordered = unordered_q;

endmodule

// File: tb/tb_fp_compare.sv
// Self-checking bench for fp_compare: directed cases, handshake/reset behaviour, random vs. value-key model.
module tb_fp_compare;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fp_compare_if #(.PRECISION(32)) bus ();

  fp_compare #(
    .PRECISION(32),
    .EXP_SIZE(8),
    .MANTISSA_SIZE(23)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic bit m_snan(input logic [31:0] x);
    return m_nan(x) && !x[22];
  endfunction

  // Map an ordered float onto a signed integer line; both zeros land on 0.
  function automatic longint m_key(input logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
`ifdef FP_COMPARE_FTZ_EN
    if (x[30:23] == 0) mag = 0;
`endif
    return x[31] ? -mag : mag;
  endfunction

  function automatic logic [2:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit nan, snan, r, inv;
    longint ka, kb;
    nan  = m_nan(a) || m_nan(b);
    snan = m_snan(a) || m_snan(b);
    ka = m_key(a);
    kb = m_key(b);
    case (op)
      2'd0: r = !nan && (ka == kb);
      2'd1: r = !nan && (ka < kb);
      2'd2: r = !nan && (ka <= kb);
      default: r = nan;
    endcase
    inv = (op == 2'd1 || op == 2'd2) ? nan : snan;
    return {r, inv, nan};
  endfunction

  // Issue one compare from IDLE and wait for done; leaves time at the negedge where done is high.
  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.fp_a  = a;
    bus.fp_b  = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.fp_a  = $urandom;
    bus.fp_b  = $urandom;
    bus.op    = 2'($urandom_range(0, 3));
    chk({tag, ".busy"}, bus.busy, 1);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, 3);
  endtask

  task automatic directed(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic er, input logic ei, input logic eu);
    issue(tag, op, a, b);
    chk({tag, ".res"}, bus.res, er);
    chk({tag, ".invalid"}, bus.invalid, ei);
    chk({tag, ".unordered"}, bus.unordered, eu);
  endtask

  task automatic random_case(input int idx);
    logic [31:0] pool [10];
    logic [31:0] a, b;
    logic [1:0]  op;
    logic [2:0]  exp;
    pool = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000, 32'h7F800000,
             32'hFF800000, 32'h7FC00000, 32'h7F800001, 32'h00000001, 32'h807FFFFF};
    a  = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 9)] : $urandom;
    case ($urandom_range(0, 3))
      0:       b = a;
      1:       b = {~a[31], a[30:0]};
      2:       b = pool[$urandom_range(0, 9)];
      default: b = $urandom;
    endcase
    op  = 2'($urandom_range(0, 3));
    exp = model(op, a, b);
    issue($sformatf("rnd%0d", idx), op, a, b);
    checks++;
    assert ({bus.res, bus.invalid, bus.unordered} === exp) else begin
      errors++;
      $error("FAIL rnd%0d op=%0d a=%h b=%h observed=%b expected=%b", idx, op, a, b,
             {bus.res, bus.invalid, bus.unordered}, exp);
    end
  endtask

  initial begin
    int ndone;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.fp_a  = '0;
    bus.fp_b  = '0;

    #12;
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.flags", {bus.res, bus.invalid, bus.unordered}, 0);
    @(negedge clk);
    reset = 1'b1;

    directed("eq_zeros", 2'd0, 32'h00000000, 32'h80000000, 1, 0, 0);
    directed("lt_1_2",   2'd1, 32'h3F800000, 32'h40000000, 1, 0, 0);
    directed("lt_2_1",   2'd1, 32'h40000000, 32'h3F800000, 0, 0, 0);
    directed("lt_m1_1",  2'd1, 32'hBF800000, 32'h3F800000, 1, 0, 0);
    directed("lt_m2_m1", 2'd1, 32'hC0000000, 32'hBF800000, 1, 0, 0);
    directed("le_ninf",  2'd2, 32'hFF800000, 32'hFF800000, 1, 0, 0);
    directed("lt_pz_mz", 2'd1, 32'h00000000, 32'h80000000, 0, 0, 0);
    directed("eq_qnan",  2'd0, 32'h7FC00000, 32'h7FC00000, 0, 0, 1);
    directed("lt_qnan",  2'd1, 32'h7FC00000, 32'h7FC00000, 0, 1, 1);
    directed("eq_snan",  2'd0, 32'h7F800001, 32'h3F800000, 0, 1, 1);
    directed("un_qnan",  2'd3, 32'h7FC00000, 32'h00000000, 1, 0, 1);
    directed("un_snan",  2'd3, 32'h3F800000, 32'h7F800001, 1, 1, 1);
`ifdef FP_COMPARE_FTZ_EN
    directed("ftz_eq",   2'd0, 32'h00000001, 32'h00000000, 1, 0, 0);
    directed("ftz_lt",   2'd1, 32'h00000001, 32'h00000002, 0, 0, 0);
`else
    directed("ftz_eq",   2'd0, 32'h00000001, 32'h00000000, 0, 0, 0);
    directed("ftz_lt",   2'd1, 32'h00000001, 32'h00000002, 1, 0, 0);
`endif

    // start held high: one done every four cycles
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd1;
    bus.fp_a  = 32'h3F800000;
    bus.fp_b  = 32'h40000000;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk($sformatf("held.done%0d", i), bus.done, (i % 4 == 3) ? 1 : 0);
    end
    bus.start = 1'b0;
    chk("held.res", bus.res, 1);

    // a start pulse during busy must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.fp_a  = 32'h3F800000;
    bus.fp_b  = 32'h3F800000;
    @(negedge clk);
    bus.op    = 2'd3;
    bus.fp_a  = 32'h7FC00000;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("ign.done", bus.done, 1);
    chk("ign.flags", {bus.res, bus.invalid, bus.unordered}, 3'b100);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("ign.no_second_done", ndone, 0);

    // reset asserted while in COMPARE aborts the request
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd1;
    bus.fp_a  = 32'h3F800000;
    bus.fp_b  = 32'h40000000;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort.busy", bus.busy, 0);
    chk("abort.done", bus.done, 0);
    chk("abort.flags", {bus.res, bus.invalid, bus.unordered}, 0);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("abort.no_done", ndone, 0);

    directed("post_abort", 2'd2, 32'hBF800000, 32'hBF800000, 1, 0, 0);

    for (int i = 0; i < 250; i++) random_case(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
